// File: rtl/large_integer_to_float.sv
// Converts a 279-bit two's-complement fixed-point value (LSB weight 2^-150) to IEEE-754 single
// precision with round-to-nearest-even; leading-one search scans CHUNK_W bits per cycle.
module large_integer_to_float #(
    parameter int unsigned CHUNK_W = 32
) (
    input  logic         clk_i,
    input  logic         arst_n_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [278:0] in_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [31:0]  out_o
);

    localparam int unsigned IN_W   = 279;
    localparam int unsigned NCHUNK = (IN_W + CHUNK_W - 1) / CHUNK_W;
    localparam int unsigned PAD_W  = NCHUNK * CHUNK_W;
    localparam int unsigned PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [2:0] {StIdle, StMag, StScan, StPack, StOut} state_e;

    state_e             r_state, w_state_d;
    logic               r_sign;
    logic [PAD_W-1:0]   r_mag;
    logic [PTR_W-1:0]   r_ptr;
    logic [31:0]        r_out;

    logic [9:0]         w_base;
    logic [CHUNK_W-1:0] w_chunk;
    logic [IN_W-1:0]    w_abs;
    logic [9:0]         w_p;
    logic [9:0]         w_s;
    logic [9:0]         w_s_fin;
    logic [23:0]        w_tr;
    logic               w_guard;
    logic               w_sticky;
    logic [24:0]        w_q;
    logic [24:0]        w_q_fin;
    logic [31:0]        w_out;

    assign w_base  = 10'(r_ptr) * 10'(CHUNK_W);
    assign w_chunk = CHUNK_W'(r_mag >> w_base);
    assign w_abs   = r_sign ? (-r_mag[IN_W-1:0]) : r_mag[IN_W-1:0];

    always_comb begin
        w_state_d   = r_state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (r_state)
            StIdle: begin
                in_ready_o = arst_n_i;
                if (in_valid_i) w_state_d = StMag;
            end
            StMag:  w_state_d = StScan;
            StScan: begin
                if (!(w_chunk == '0 && r_ptr != '0)) w_state_d = StPack;
            end
            StPack: w_state_d = StOut;
            StOut: begin
                out_valid_o = 1'b1;
                if (out_ready_i) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Shift so that at most 24 significant bits remain; s never drops below the subnormal scale.
    always_comb begin
        w_p = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            if (w_chunk[i]) w_p = w_base + 10'(i);
        end
        w_s      = (w_p >= 10'd24) ? (w_p - 10'd23) : 10'd1;
        w_tr     = 24'(r_mag >> w_s);
        w_guard  = 1'(r_mag >> (w_s - 10'd1));
        w_sticky = |(r_mag & ~({PAD_W{1'b1}} << (w_s - 10'd1)));
        w_q      = {1'b0, w_tr} + 25'(w_guard & (w_sticky | w_tr[0]));
        w_q_fin  = w_q;
        w_s_fin  = w_s;
        if (w_q[24]) begin
            w_q_fin = 25'h080_0000;
            w_s_fin = w_s + 10'd1;
        end
        if (w_q_fin == '0) begin
            w_out = 32'h0;
        end else if (w_s_fin >= 10'd255) begin
            w_out = {r_sign, 8'hFF, 23'h0};
        end else begin
            w_out = {r_sign, (w_q_fin[23] ? w_s_fin[7:0] : 8'h00), w_q_fin[22:0]};
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_sign <= 1'b0;
            r_mag  <= '0;
            r_ptr  <= '0;
            r_out  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid_i) begin
                        r_sign <= in_i[IN_W-1];
                        r_mag  <= PAD_W'(in_i);
                    end
                end
                StMag: begin
                    r_mag <= PAD_W'(w_abs);
                    r_ptr <= PTR_W'(NCHUNK - 1);
                end
                StScan: begin
                    if (w_chunk == '0 && r_ptr != '0) r_ptr <= r_ptr - 1'b1;
                end
                StPack: r_out <= w_out;
                default: ;
            endcase
        end
    end

    assign out_o = r_out;

endmodule

// File: tb/tb_large_integer_to_float.sv
// Directed bench for large_integer_to_float: hand-computed vectors, latency, backpressure,
// mid-conversion reset and a float round-trip.
module tb_large_integer_to_float;

    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [278:0] in_v = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_v;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    large_integer_to_float #(.CHUNK_W(32)) dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_i       (in_v),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_o      (out_v)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic run(input logic [278:0] v, input logic [31:0] exp_out, input int exp_lat,
                       input int hold, input string tag);
        int lat;
        @(negedge clk);
        in_v      = v;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ":ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ":valid"}, 32'(out_valid), 32'd1);
        if (exp_lat >= 0) chk({tag, ":lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ":out"}, out_v, exp_out);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk({tag, ":hold_v"}, 32'(out_valid), 32'd1);
            chk({tag, ":hold_o"}, out_v, exp_out);
            chk({tag, ":hold_r"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ":drain"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [278:0] one;
        logic [278:0] v;
        logic [7:0]   e;
        logic [22:0]  fr;
        logic         sg;
        int           lat;
        one = 279'd1;

        #12;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_out", out_v, 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        run(one << 150, 32'h3F80_0000, 7, 0, "one");
        run(-(279'd3 << 149), 32'hBFC0_0000, -1, 0, "neg1p5");
        run('0, 32'h0, 11, 0, "zero");
        run({279{1'b1}}, 32'h0, -1, 0, "minus1");
        run((one << 150) + (one << 126), 32'h3F80_0000, -1, 0, "tie_even");
        run((one << 150) + (one << 126) + one, 32'h3F80_0001, -1, 0, "tie_sticky");
        v = ((one << 24) - one) << 254;
        run(v, 32'h7F7F_FFFF, -1, 0, "maxfin");
        run(v + (one << 253), 32'h7F80_0000, -1, 0, "ovf_inf");
        run(-(one << 278), 32'hFF80_0000, 3, 0, "most_neg");
        run(279'd2, 32'h0000_0001, -1, 0, "sub_min");
        run(279'd3, 32'h0000_0002, -1, 0, "sub_tie");
        run(one << 24, 32'h0080_0000, -1, 0, "min_norm");
        run(-(one << 150), 32'hBF80_0000, -1, 10, "hold");

        // Reset asserted while the zero input is still being scanned.
        @(negedge clk);
        in_v     = '0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        arst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_out", out_v, 32'h0);
        lat = 0;
        while (!out_valid && lat < 15) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("mid_rst_quiet", 32'(out_valid), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        run(-(279'd3 << 149), 32'hBFC0_0000, -1, 0, "after_rst");

        for (int n = 0; n < 8; n++) begin
            e  = 8'($urandom_range(1, 254));
            fr = 23'($urandom);
            sg = 1'($urandom);
            v  = ((one << 23) | 279'(fr)) << e;
            if (sg) v = -v;
            run(v, {sg, e, fr}, -1, 0, "roundtrip");
        end
        run('0, 32'h0, -1, 0, "negzero_rt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
